// File: rtl/uart_pkg.sv
// uart_pkg: constants, FSM state encoding and baud helper shared by the
// uart transmitter and receiver.
package uart_pkg;

  // Parity modes; any other value of the check parameter means no parity.
  localparam int CHECK_NONE = 0;
  localparam int CHECK_ODD  = 1;
  localparam int CHECK_EVEN = 2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

  // Clock cycles per line bit, truncated; the result must be at least 2.
  function automatic int unsigned calc_bit_cycles(input int unsigned clk_hz,
                                                  input int unsigned baud_hz);
    return clk_hz / baud_hz;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: bit-period counter. Held at zero while i_clr is high and
// pulses o_bit_done on the last cycle of every BIT_CYCLES-long bit period.
// The counter wraps on o_bit_done, so consecutive bits never drift.
module uart_baud_gen #(
  parameter int unsigned BIT_CYCLES = 16
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clr,
  output logic o_bit_done
);

  localparam int unsigned CNT_W = $clog2(BIT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_r;
  logic             last_s;

  assign last_s     = (cnt_r == CNT_LAST);
  assign o_bit_done = last_s && !i_clr;

  // Count cycles within the current bit, restarting on clear or bit end.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cnt_r <= '0;
    end else if (i_clr) begin
      cnt_r <= '0;
    end else if (last_s) begin
      cnt_r <= '0;
    end else begin
      cnt_r <= cnt_r + CNT_W'(1);
    end
  end

endmodule

// File: rtl/uart_tx.sv
// uart_tx: UART serial transmitter. Frame = start bit, data MSB first,
// optional parity, stop bit(s). Valid/ready word input, registered outputs.
// Optional feature: define UART_TX_BUF_EN to add a one-word holding register
// so a word can be accepted during a frame and sent with zero idle gap.
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned buad_rate       = 9600,
  parameter int unsigned clk_rate        = 50_000_000,
  parameter int unsigned uart_data_width = 8,
  parameter int          check           = 1,
  parameter int unsigned stop_width      = 1
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic [uart_data_width-1:0] i_tx_data,
  input  logic                       i_tx_valid,
  output logic                       o_tx_ready,
  output logic                       o_tx,
  output logic                       o_tx_busy
);

  localparam int unsigned BIT_CYCLES = calc_bit_cycles(clk_rate, buad_rate);
  localparam bit          PAR_EN     = (check == CHECK_ODD) || (check == CHECK_EVEN);
  localparam int unsigned BIT_CNT_W  = $clog2(uart_data_width + 1);
  localparam logic [BIT_CNT_W-1:0] DATA_LAST = BIT_CNT_W'(uart_data_width - 1);
  localparam logic [BIT_CNT_W-1:0] STOP_LAST = BIT_CNT_W'(stop_width - 1);

  // Parity bit for a data word in the configured mode.
  function automatic logic calc_parity(input logic [uart_data_width-1:0] data);
    if (check == CHECK_EVEN) begin
      return ^data;
    end else begin
      return ~^data;
    end
  endfunction

  uart_state_e                state_r;
  logic [uart_data_width-1:0] shift_r;
  logic [uart_data_width-1:0] shifted_s;
  logic [BIT_CNT_W-1:0]       bit_cnt_r;
  logic                       parity_r;
  logic                       tx_r;
  logic                       ready_r;
  logic                       busy_r;
  logic                       bit_done_s;
  logic                       baud_clr_s;
  logic                       accept_s;
  logic                       frame_end_s;

  assign o_tx       = tx_r;
  assign o_tx_ready = ready_r;
  assign o_tx_busy  = busy_r;

  assign accept_s    = i_tx_valid && ready_r;
  assign baud_clr_s  = (state_r == ST_IDLE);
  assign frame_end_s = (state_r == ST_STOP) && bit_done_s && (bit_cnt_r == STOP_LAST);
  assign shifted_s   = shift_r << 1'b1;

  uart_baud_gen #(
    .BIT_CYCLES (BIT_CYCLES)
  ) u_baud (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_clr      (baud_clr_s),
    .o_bit_done (bit_done_s)
  );

`ifdef UART_TX_BUF_EN
  logic [uart_data_width-1:0] hold_r;
  logic                       hold_full_r;
  logic                       hold_full_next_s;
  logic                       direct_load_s;
  logic                       hold_load_s;
  logic                       hold_drain_s;

  // Route an accepted word straight into the frame when the line is free,
  // otherwise park it; the holding register drains at the end of a frame.
  always_comb begin
    direct_load_s = accept_s && ((state_r == ST_IDLE) || (frame_end_s && !hold_full_r));
    hold_load_s   = accept_s && !direct_load_s;
    hold_drain_s  = frame_end_s && hold_full_r;
    if (hold_load_s) begin
      hold_full_next_s = 1'b1;
    end else if (hold_drain_s) begin
      hold_full_next_s = 1'b0;
    end else begin
      hold_full_next_s = hold_full_r;
    end
  end

  // Holding register for the next word.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      hold_r      <= '0;
      hold_full_r <= 1'b0;
    end else begin
      hold_full_r <= hold_full_next_s;
      if (hold_load_s) begin
        hold_r <= i_tx_data;
      end else begin
        hold_r <= hold_r;
      end
    end
  end

  // Ready mirrors an empty holding register, regardless of the FSM state.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      ready_r <= 1'b1;
    end else begin
      ready_r <= !hold_full_next_s;
    end
  end
`else
  // Ready drops after a handshake and returns when the FSM is back in IDLE.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      ready_r <= 1'b1;
    end else if (accept_s) begin
      ready_r <= 1'b0;
    end else if (frame_end_s || (state_r == ST_IDLE)) begin
      ready_r <= 1'b1;
    end else begin
      ready_r <= ready_r;
    end
  end
`endif

  // Frame sequencer: drives the line one bit period per state step.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_r   <= ST_IDLE;
      shift_r   <= '0;
      bit_cnt_r <= '0;
      parity_r  <= 1'b0;
      tx_r      <= 1'b1;
      busy_r    <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          bit_cnt_r <= '0;
          if (accept_s) begin
            shift_r  <= i_tx_data;
            parity_r <= calc_parity(i_tx_data);
            state_r  <= ST_START;
            tx_r     <= 1'b0;
            busy_r   <= 1'b1;
          end else begin
            tx_r   <= 1'b1;
            busy_r <= 1'b0;
          end
        end
        ST_START: begin
          if (bit_done_s) begin
            state_r   <= ST_DATA;
            tx_r      <= shift_r[uart_data_width-1];
            bit_cnt_r <= '0;
          end else begin
            tx_r <= 1'b0;
          end
        end
        ST_DATA: begin
          if (bit_done_s) begin
            if (bit_cnt_r == DATA_LAST) begin
              bit_cnt_r <= '0;
              if (PAR_EN) begin
                state_r <= ST_PARITY;
                tx_r    <= parity_r;
              end else begin
                state_r <= ST_STOP;
                tx_r    <= 1'b1;
              end
            end else begin
              bit_cnt_r <= bit_cnt_r + BIT_CNT_W'(1);
              shift_r   <= shifted_s;
              tx_r      <= shifted_s[uart_data_width-1];
            end
          end else begin
            tx_r <= shift_r[uart_data_width-1];
          end
        end
        ST_PARITY: begin
          if (bit_done_s) begin
            state_r   <= ST_STOP;
            tx_r      <= 1'b1;
            bit_cnt_r <= '0;
          end else begin
            tx_r <= parity_r;
          end
        end
        ST_STOP: begin
          if (frame_end_s) begin
            bit_cnt_r <= '0;
`ifdef UART_TX_BUF_EN
            if (hold_full_r) begin
              shift_r  <= hold_r;
              parity_r <= calc_parity(hold_r);
              state_r  <= ST_START;
              tx_r     <= 1'b0;
            end else if (direct_load_s) begin
              shift_r  <= i_tx_data;
              parity_r <= calc_parity(i_tx_data);
              state_r  <= ST_START;
              tx_r     <= 1'b0;
            end else begin
              state_r <= ST_IDLE;
              tx_r    <= 1'b1;
              busy_r  <= 1'b0;
            end
`else
            state_r <= ST_IDLE;
            tx_r    <= 1'b1;
            busy_r  <= 1'b0;
`endif
          end else if (bit_done_s) begin
            bit_cnt_r <= bit_cnt_r + BIT_CNT_W'(1);
            tx_r      <= 1'b1;
          end else begin
            tx_r <= 1'b1;
          end
        end
        default: begin
          state_r   <= ST_IDLE;
          bit_cnt_r <= '0;
          tx_r      <= 1'b1;
          busy_r    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed bench for uart_tx with BIT_CYCLES = 16.
// Three instances: odd parity / 1 stop, even parity / 1 stop, no parity / 2 stop.
module tb_uart_tx;

`ifdef UART_TX_BUF_EN
  localparam logic BUF_EN = 1'b1;
`else
  localparam logic BUF_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] data_s  [3];
  logic       valid_s [3];
  logic       tx_s    [3];
  logic       ready_s [3];
  logic       busy_s  [3];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  uart_tx #(.buad_rate(1), .clk_rate(16), .uart_data_width(8), .check(1), .stop_width(1)) dut_odd (
    .i_clk(clk), .i_rst(rst), .i_tx_data(data_s[0]), .i_tx_valid(valid_s[0]),
    .o_tx_ready(ready_s[0]), .o_tx(tx_s[0]), .o_tx_busy(busy_s[0]));

  uart_tx #(.buad_rate(1), .clk_rate(16), .uart_data_width(8), .check(2), .stop_width(1)) dut_even (
    .i_clk(clk), .i_rst(rst), .i_tx_data(data_s[1]), .i_tx_valid(valid_s[1]),
    .o_tx_ready(ready_s[1]), .o_tx(tx_s[1]), .o_tx_busy(busy_s[1]));

  uart_tx #(.buad_rate(1), .clk_rate(16), .uart_data_width(8), .check(0), .stop_width(2)) dut_none (
    .i_clk(clk), .i_rst(rst), .i_tx_data(data_s[2]), .i_tx_valid(valid_s[2]),
    .o_tx_ready(ready_s[2]), .o_tx(tx_s[2]), .o_tx_busy(busy_s[2]));

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Checks 176 cycles of one frame, starting at the current negedge (cycle 0
  // = first cycle after the handshake). exp holds the 11 line bits, first
  // bit in exp[10]. With push set, a second word is offered during cycle 0.
  task automatic check_frame(input int d, input logic [10:0] exp, input string tag,
                             input logic push, input logic [7:0] push_word);
    for (int k = 0; k < 176; k++) begin
      if (k > 0) @(negedge clk);
      chk({tag, " line"}, tx_s[d], exp[10 - k / 16]);
      chk({tag, " busy"}, busy_s[d], 1'b1);
      if (push && k == 0) begin
        valid_s[d] = 1'b1;
        data_s[d]  = push_word;
      end
      if (push && k == 1) begin
        chk({tag, " ready after push"}, ready_s[d], 1'b0);
        valid_s[d] = 1'b0;
      end
    end
  endtask

  // One isolated frame: handshake, data scrambled afterwards, full line check.
  task automatic send_check(input int d, input logic [7:0] w, input logic [10:0] exp,
                            input string tag);
    @(negedge clk);
    chk({tag, " idle ready"}, ready_s[d], 1'b1);
    chk({tag, " idle line"}, tx_s[d], 1'b1);
    valid_s[d] = 1'b1;
    data_s[d]  = w;
    @(posedge clk);
    @(negedge clk);
    valid_s[d] = 1'b0;
    data_s[d]  = ~w;
    chk({tag, " ready in frame"}, ready_s[d], BUF_EN);
    check_frame(d, exp, tag, 1'b0, 8'h00);
    @(negedge clk);
    chk({tag, " end line"}, tx_s[d], 1'b1);
    chk({tag, " end ready"}, ready_s[d], 1'b1);
    chk({tag, " end busy"}, busy_s[d], 1'b0);
  endtask

  logic [7:0]  b2b_w [3] = '{8'h3C, 8'hC3, 8'h01};
  logic [10:0] b2b_e [3] = '{11'b0_00111100_1_1, 11'b0_11000011_1_1, 11'b0_00000001_0_1};

  initial begin
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      valid_s[i] = 1'b0;
      data_s[i]  = 8'h00;
    end
    #12;
    for (int i = 0; i < 3; i++) begin
      chk("reset line", tx_s[i], 1'b1);
      chk("reset ready", ready_s[i], 1'b1);
      chk("reset busy", busy_s[i], 1'b0);
    end
    @(negedge clk);
    rst = 1'b0;

    // Odd parity, 8'hA5: 4 ones -> parity 1.
    send_check(0, 8'hA5, 11'b0_10100101_1_1, "odd A5");
    // Even parity: 8'h07 -> 1, 8'h03 -> 0.
    send_check(1, 8'h07, 11'b0_00000111_1_1, "even 07");
    send_check(1, 8'h03, 11'b0_00000011_0_1, "even 03");
    // No parity, two stop bits: 32 high cycles after the data.
    send_check(2, 8'hFF, 11'b0_11111111_1_1, "none FF");

    // Reset in the third data bit of 8'h5A (line low there).
    @(negedge clk);
    valid_s[0] = 1'b1;
    data_s[0]  = 8'h5A;
    @(posedge clk);
    @(negedge clk);
    valid_s[0] = 1'b0;
    repeat (56) @(negedge clk);
    chk("pre-reset line", tx_s[0], 1'b0);
    chk("pre-reset busy", busy_s[0], 1'b1);
    #2;
    rst = 1'b1;
    #1;
    chk("async reset line", tx_s[0], 1'b1);
    chk("async reset ready", ready_s[0], 1'b1);
    chk("async reset busy", busy_s[0], 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    send_check(0, 8'h5A, 11'b0_01011010_1_1, "after reset 5A");

`ifdef UART_TX_BUF_EN
    // Second word accepted mid-frame, starts with zero idle gap.
    @(negedge clk);
    valid_s[0] = 1'b1;
    data_s[0]  = 8'h96;
    @(posedge clk);
    @(negedge clk);
    valid_s[0] = 1'b0;
    data_s[0]  = 8'h00;
    chk("buf ready in frame", ready_s[0], 1'b1);
    check_frame(0, 11'b0_10010110_1_1, "buf 96", 1'b1, 8'h80);
    @(negedge clk);
    chk("buf ready drained", ready_s[0], 1'b1);
    check_frame(0, 11'b0_10000000_0_1, "buf 80", 1'b0, 8'h00);
    @(negedge clk);
    chk("buf end line", tx_s[0], 1'b1);
    chk("buf end busy", busy_s[0], 1'b0);
`else
    // Valid held high with three words: one idle cycle between frames.
    @(negedge clk);
    valid_s[0] = 1'b1;
    data_s[0]  = b2b_w[0];
    for (int f = 0; f < 3; f++) begin
      @(posedge clk);
      @(negedge clk);
      if (f < 2) begin
        data_s[0] = b2b_w[f + 1];
      end else begin
        data_s[0]  = 8'hAA;
        valid_s[0] = 1'b0;
      end
      chk("b2b ready in frame", ready_s[0], 1'b0);
      check_frame(0, b2b_e[f], "b2b", 1'b0, 8'h00);
      @(negedge clk);
      chk("b2b gap line", tx_s[0], 1'b1);
      chk("b2b gap ready", ready_s[0], 1'b1);
      chk("b2b gap busy", busy_s[0], 1'b0);
    end
    repeat (20) begin
      @(negedge clk);
      chk("b2b no 4th frame line", tx_s[0], 1'b1);
      chk("b2b no 4th frame busy", busy_s[0], 1'b0);
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
